// File: rtl/lsu_ctrl_if.sv
// Data-memory port bundle between lsu_ctrl (master) and the data memory (slave).
// Request/grant/response handshake with word-aligned address and byte enables.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: effective address, byte lanes, load extension and memory handshake with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] base,
    input  logic [31:0]       imm,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    lsu_ctrl_if.master        mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout;

    logic [ADDR_W-1:0] ea;
    logic [1:0]        off;
    logic [3:0]        be_n;
    logic [DATA_W-1:0] wd_n;

    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wd_q;
    logic              we_q;
    logic [1:0]        sz_q;
    logic [1:0]        off_q;
    logic              uns_q;

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ld;

    // Effective address and the lane offset actually used for the access
    always_comb begin
        ea = base + ADDR_W'(signed'(imm));
        case (size)
            2'b00:   off = ea[1:0];
            2'b01:   off = {ea[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    always_comb begin
        misal = ((size == 2'b01) && ea[0]) || (size[1] && (ea[1:0] != 2'b00));
    end
`endif

    always_comb begin
        case (size)
            2'b00: begin
                be_n = 4'b0001 << off;
                wd_n = {(DATA_W/8){wdata[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << {off[1], 1'b0};
                wd_n = {(DATA_W/16){wdata[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = wdata;
            end
        endcase
    end

    always_comb begin
        sh = mem.mem_rdata >> {off_q, 3'b000};
        case (sz_q)
            2'b00:   ld = uns_q ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                            : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'b01:   ld = uns_q ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                            : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: ld = sh;
        endcase
    end

    // Counter spans REQ and WAIT together; >= keeps it safe once past the limit
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        mem.mem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misal ? S_ERR : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_gnt)
                    state_d = we_q ? S_DONE : S_WAIT;
                else if (timeout)
                    state_d = S_ERR;
            end
            S_WAIT: begin
                if (mem.mem_rvalid)
                    state_d = S_DONE;
                else if (timeout)
                    state_d = S_ERR;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (state_q == S_IDLE)
            cnt_q <= '0;
        else if ((state_q == S_REQ) || (state_q == S_WAIT))
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            be_q   <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            sz_q   <= '0;
            off_q  <= '0;
            uns_q  <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            addr_q <= {ea[ADDR_W-1:2], 2'b00};
            be_q   <= be_n;
            wd_q   <= wd_n;
            we_q   <= is_store;
            sz_q   <= size;
            off_q  <= off;
            uns_q  <= unsigned_ld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if ((state_q == S_WAIT) && mem.mem_rvalid)
            rdata <= ld;
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wd_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. It latches a memory operation, forms the effective address (`base + imm`), and drives a request/grant/response handshake to data memory. It also generates byte enables and write-data lanes, aligns and extends load data, and stalls the pipeline through `busy` until the access completes or times out. It is the sole owner of the data-memory port in the core.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed lane logic assumes 32)
- `TIMEOUT_CYC`, 255, max cycles in REQ+WAIT before abort (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  issue op; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `unsigned_ld`  in  1  zero-extend load (else sign-extend)
- `base`  in  ADDR_W  rs1 value
- `imm`  in  32  sign-extended offset (I- or S-form, pre-selected)
- `wdata`  in  DATA_W  store data (rs2)
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; 1 = aborted
- `rdata`  out  DATA_W  load result, valid with `done` and held until next `done`
- `mem_req`  out  1  request, held until `mem_gnt`
- `mem_we`  out  1  write
- `mem_addr`  out  ADDR_W  word-aligned address (`addr[1:0]` = 0)
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_gnt`  in  1  request accepted
- `mem_rvalid`  in  1  load data valid, ≥1 cycle after grant
- `mem_rdata`  in  DATA_W  load data

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, `start`=1: register `addr = base + imm` (modulo 2^ADDR_W, carry discarded), `size`, `unsigned_ld`, `is_store`, `wdata`. Next state is REQ.
- REQ: `mem_req`=1 with all `mem_*` outputs stable.
  - `mem_gnt`=1 and store: go to DONE.
  - `mem_gnt`=1 and load: go to WAIT.
- WAIT: `mem_req`=0. `mem_rvalid`=1 captures the aligned, extended data into `rdata` and goes to DONE.
- DONE: `done`=1, `err`=0. Return to IDLE.
- ERR: `done`=1, `err`=1, `rdata` unchanged. Return to IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],0}`
  - word: `4'b1111`
- Write lanes: byte replicates `wdata[7:0]` ×4; half replicates `[15:0]` ×2; word passes through.
- Load alignment: `mem_rdata >> (8*addr[1:0])`, then take the low 8/16/32 bits and extend per `unsigned_ld`.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ or WAIT. After TIMEOUT_CYC cycles without `mem_gnt`/`mem_rvalid`, go to ERR. If completion and timeout fall in the same cycle, completion wins.
- `mem_rvalid` outside WAIT, and `mem_gnt` outside REQ, are ignored.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_be` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0.
- `rst_n` low mid-operation aborts immediately with no `done`. An in-flight response arriving after reset is ignored.
- `start` at cycle 0 puts `mem_req` high in cycle 1.
- Store, zero-wait grant: `done` in cycle 2.
- Load, grant in cycle 1 and `rvalid` in cycle 2: `done` and `rdata` in cycle 3.
- `busy` is high from cycle 1 through the `done` cycle inclusive. Back-to-back `start` is accepted the cycle after `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half-word access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, skips REQ.
  - Path is IDLE→ERR, so `done`=`err`=1 in cycle 1.
  - `mem_req` is never asserted for the misaligned op.
- `LSU_MISALIGN_TRAP_EN` undefined: low address bits are forced to alignment (half clears bit 0, word clears bits 1:0) and the access proceeds. `err` is set only on timeout.

## Test plan
- Store word: base=0x100, imm=0x4, wdata=0xDEADBEEF, grant in cycle 1. Expect `mem_addr`=0x104, `mem_be`=1111, `mem_we`=1, `done` in cycle 2, `err`=0.
- Load byte, signed: addr 0x203, `mem_rdata`=0x80AABBCC. Expect `mem_be`=1000 and `rdata`=0xFFFFFF80. With `unsigned_ld` set, expect 0x00000080.
- Store half: addr 0x102, wdata=0x1234ABCD. Expect `mem_be`=1100, `mem_wdata`=0xABCDABCD.
- Grant withheld for 3 cycles, `rvalid` 2 cycles later. Expect `mem_req` held with stable address, `busy` high throughout, `done` exactly one cycle.
- `mem_gnt` never asserted with TIMEOUT_CYC=4. Expect `done`=`err`=1 after 4 REQ cycles, and a later stray `mem_rvalid` ignored.
- Word load at addr 0x101: with the macro, expect `err`=1 and no `mem_req`. Without it, expect `mem_addr`=0x100 and a normal completion.
